// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA priority resolver
package dma_pkg;

    localparam int NUM_CH = 4;

    // Lowest-priority channel after reset: channel 3, so channel 0 wins first.
    localparam logic [1:0] LOW_PRI_RST = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } dma_pri_state_t;

    // One-hot decode of a channel number.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
        logic [NUM_CH-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dma_pri_encoder.sv
// rtl/dma_pri_encoder.sv - rotating priority encoder over the effective requests
module dma_pri_encoder
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] effReq,
    input  logic [1:0]        lowPri,
    output logic              any,
    output logic [1:0]        winner
);

    logic [1:0] w_idx;
    logic       w_found;

    // Walk the channels starting just above the lowest-priority one; first set bit wins.
    always_comb begin
        winner  = 2'd0;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = lowPri + 2'(i + 1);
            if (!w_found && effReq[w_idx]) begin
                winner  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign any = |effReq;

endmodule

// File: rtl/dma_priority_resolver.sv
// rtl/dma_priority_resolver.sv - DREQ qualification, arbitration and DACK generation
module dma_priority_resolver
    import dma_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] reqReg,
    input  logic              ctrlDisable,
    input  logic              rotatePri,
    input  logic              dreqSenseLow,
    input  logic              dackSenseHigh,
    input  logic              hrq,
    input  logic              validDACK,
    output logic              VALID_DREQ0,
    output logic              VALID_DREQ1,
    output logic              VALID_DREQ2,
    output logic              VALID_DREQ3,
    output logic [NUM_CH-1:0] DACK
);

    dma_pri_state_t    r_state;
    logic [1:0]        r_winner;
    logic [NUM_CH-1:0] r_ack_vec;
    logic [1:0]        r_low_pri;
    logic [NUM_CH-1:0] r_valid;

    dma_pri_state_t    w_state_nxt;
    logic [1:0]        w_winner_nxt;
    logic [NUM_CH-1:0] w_ack_nxt;
    logic [1:0]        w_low_pri_nxt;
    logic [NUM_CH-1:0] w_valid_nxt;

    logic [NUM_CH-1:0] w_eff_req;
    logic [1:0]        w_search_low;
    logic              w_any;
    logic [1:0]        w_enc_winner;

    // Hardware requests honour sense polarity and mask; software requests bypass the mask.
    assign w_eff_req = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | reqReg;

    // Fixed mode searches as if channel 3 were lowest; the stored pointer is kept untouched.
    assign w_search_low = rotatePri ? r_low_pri : LOW_PRI_RST;

    dma_pri_encoder u_encoder (
        .effReq (w_eff_req),
        .lowPri (w_search_low),
        .any    (w_any),
        .winner (w_enc_winner)
    );

    // Next-state logic for the request/service handshake with timing-and-control.
    always_comb begin
        w_state_nxt   = r_state;
        w_winner_nxt  = r_winner;
        w_ack_nxt     = r_ack_vec;
        w_low_pri_nxt = r_low_pri;
        case (r_state)
            IDLE: begin
                w_ack_nxt = '0;
                if (!ctrlDisable && w_any) begin
                    w_state_nxt  = REQUEST;
                    w_winner_nxt = w_enc_winner;
                end
            end
            REQUEST: begin
                // validDACK takes precedence over a request dropping in the same cycle.
                if (validDACK) begin
                    w_state_nxt = SERVICE;
                    w_ack_nxt   = ch_onehot(r_winner);
                end else if (!w_eff_req[r_winner]) begin
                    w_state_nxt = IDLE;
                end
            end
            SERVICE: begin
                // Only hrq ends service; request, mask and disable changes are ignored here.
                if (!hrq) begin
                    w_state_nxt = IDLE;
                    w_ack_nxt   = '0;
                    if (rotatePri) begin
                        w_low_pri_nxt = r_winner;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ack_nxt   = '0;
            end
        endcase
    end

    // VALID_DREQ is computed from next state so it comes straight out of a flop.
    assign w_valid_nxt = (w_state_nxt != IDLE) ? ch_onehot(w_winner_nxt) : '0;

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_winner  <= 2'd0;
            r_ack_vec <= '0;
            r_low_pri <= LOW_PRI_RST;
            r_valid   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_winner  <= w_winner_nxt;
            r_ack_vec <= w_ack_nxt;
            r_low_pri <= w_low_pri_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign VALID_DREQ0 = r_valid[0];
    assign VALID_DREQ1 = r_valid[1];
    assign VALID_DREQ2 = r_valid[2];
    assign VALID_DREQ3 = r_valid[3];

    assign DACK = dackSenseHigh ? r_ack_vec : ~r_ack_vec;

    // Structural invariants of the handshake.
    a_ack_onehot : assert property (@(posedge CLK) disable iff (RESET) $onehot0(r_ack_vec));
    a_valid_onehot : assert property (@(posedge CLK) disable iff (RESET) $onehot0(r_valid));
    a_ack_in_service : assert property (@(posedge CLK) disable iff (RESET)
                                        (r_ack_vec != '0) |-> (r_state == SERVICE));

endmodule
